// File: rtl/lenet_sequencer_if.sv
// Handshake bundle between the inference sequencer and the LeNet core.
// Master is the sequencer side; slave is the LeNet side.
interface lenet_sequencer_if;
   logic       lenet_go;
   logic       lenet_srstn;
   logic       lenet_ready;
   logic [3:0] lenet_digit;

   modport master (
      output lenet_go,
      output lenet_srstn,
      input  lenet_ready,
      input  lenet_digit
   );

   modport slave (
      input  lenet_go,
      input  lenet_srstn,
      output lenet_ready,
      output lenet_digit
   );
endinterface

// File: rtl/lenet_sequencer.sv
// LeNet inference scheduler: frame sync, go/ready handshake, watchdog
// soft reset and consecutive-match digit vote.
module lenet_sequencer #(
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int VOTE_DEPTH     = 3,
   parameter int SRST_CYCLES    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              data_ready,
   lenet_sequencer_if.master lenet,
   output logic [3:0]        digit_raw,
   output logic [3:0]        digit_out,
   output logic              digit_valid,
   output logic              busy,
   output logic              timeout_err,
   output logic              overrun,
   output logic [15:0]       infer_count
);

   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SRW = $clog2(SRST_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_GO,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_LATCH,
      S_RECOVER
   } state_t;

   state_t state;
   state_t state_nxt;

   logic           dr_s1;
   logic           dr_s2;
   logic           dr_prev;
   logic           frame_evt;
   logic           pending;
   logic           go_entry;
   logic           expire;
   logic           wd_hit;
   logic [WDW-1:0] wd;
   logic [SRW-1:0] rc;
   logic           go_q;
   logic           srstn_q;
   logic           go_nxt;
   logic           srstn_nxt;
   logic           busy_nxt;
   logic [3:0]     cand;
   logic [3:0]     match_cnt;
   logic [3:0]     match_nxt;
   logic           vote_hit;

   assign frame_evt = dr_s2 & ~dr_prev;
   assign wd_hit    = wd >= WDW'(TIMEOUT_CYCLES - 1);
   assign go_entry  = state_nxt == S_GO;

   assign lenet.lenet_go    = go_q;
   assign lenet.lenet_srstn = srstn_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      expire    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (enable) state_nxt = S_ARM;
         end
         S_ARM: begin
            if (!enable)      state_nxt = S_IDLE;
            else if (pending) state_nxt = S_GO;
         end
         S_GO: begin
            state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!lenet.lenet_ready) begin
               state_nxt = S_WAIT_DONE;
            end else if (wd_hit) begin
               state_nxt = S_RECOVER;
               expire    = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (lenet.lenet_ready) begin
               state_nxt = S_LATCH;
            end else if (wd_hit) begin
               state_nxt = S_RECOVER;
               expire    = 1'b1;
            end
         end
         S_LATCH: begin
            state_nxt = enable ? S_ARM : S_IDLE;
         end
         S_RECOVER: begin
            if (rc == SRW'(SRST_CYCLES - 1))
               state_nxt = enable ? S_ARM : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they leave the flops aligned with it
   always_comb begin
      go_nxt    = 1'b0;
      srstn_nxt = 1'b1;
      busy_nxt  = 1'b0;
      unique case (1'b1)
         state_nxt == S_GO: begin
            go_nxt   = 1'b1;
            busy_nxt = 1'b1;
         end
         state_nxt == S_WAIT_BUSY,
         state_nxt == S_WAIT_DONE,
         state_nxt == S_LATCH: begin
            busy_nxt = 1'b1;
         end
         state_nxt == S_RECOVER: begin
            srstn_nxt = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      match_nxt = 4'd1;
      if (lenet.lenet_digit == cand)
         match_nxt = (match_cnt == 4'hF) ? 4'hF : match_cnt + 4'd1;
      vote_hit = match_nxt >= 4'(VOTE_DEPTH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dr_s1       <= 1'b0;
         dr_s2       <= 1'b0;
         dr_prev     <= 1'b0;
         pending     <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
         wd          <= '0;
         rc          <= '0;
         go_q        <= 1'b0;
         srstn_q     <= 1'b1;
         busy        <= 1'b0;
         digit_raw   <= 4'd0;
         digit_out   <= 4'd0;
         digit_valid <= 1'b0;
         infer_count <= 16'd0;
         cand        <= 4'd0;
         match_cnt   <= 4'd0;
      end else begin
         dr_s1   <= data_ready;
         dr_s2   <= dr_s1;
         dr_prev <= dr_s2;
         // An event coinciding with GO entry survives for the next round
         pending <= enable & ((pending & ~go_entry) | frame_evt);
         if (frame_evt & pending & ~go_entry)
            overrun <= 1'b1;
         if (expire)
            timeout_err <= 1'b1;
         if (state == S_GO)
            wd <= WDW'(1);
         else if (state == S_WAIT_BUSY || state == S_WAIT_DONE)
            wd <= wd + WDW'(1);
         if (expire)
            rc <= '0;
         else if (state == S_RECOVER)
            rc <= rc + SRW'(1);
         go_q    <= go_nxt;
         srstn_q <= srstn_nxt;
         busy    <= busy_nxt;
         if (state == S_LATCH) begin
            digit_raw   <= lenet.lenet_digit;
            infer_count <= infer_count + 16'd1;
            cand        <= lenet.lenet_digit;
            match_cnt   <= match_nxt;
            if (vote_hit) begin
               digit_out   <= lenet.lenet_digit;
               digit_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lenet_sequencer.sv
// Bench for lenet_sequencer: LeNet behavioural model, vote table,
// hand-timed corner sequences and randomized frames vs a history model.
module tb_lenet_sequencer;

   localparam int T_TO = 1000;
   localparam int VD   = 3;
   localparam int SR   = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        data_ready;
   logic [3:0]  digit_raw;
   logic [3:0]  digit_out;
   logic        digit_valid;
   logic        busy;
   logic        timeout_err;
   logic        overrun;
   logic [15:0] infer_count;

   lenet_sequencer_if lif ();

   lenet_sequencer #(
      .TIMEOUT_CYCLES(T_TO),
      .VOTE_DEPTH    (VD),
      .SRST_CYCLES   (SR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .data_ready (data_ready),
      .lenet      (lif),
      .digit_raw  (digit_raw),
      .digit_out  (digit_out),
      .digit_valid(digit_valid),
      .busy       (busy),
      .timeout_err(timeout_err),
      .overrun    (overrun),
      .infer_count(infer_count)
   );

   always #5 clk = ~clk;

   int n_tests  = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int go_cnt   = 0;
   int go_cyc   = 0;
   int r_cyc    = 0;
   int cnt_cyc  = 0;
   int rise_cyc = 0;
   bit go_prev  = 1'b0;
   bit go_dbl   = 1'b0;
   logic [15:0] cnt_prev = 16'd0;

   int   m_ph   = 0;
   int   m_t    = 0;
   int   m_drop = 5;
   int   m_run  = 200;
   bit   m_hang = 1'b0;
   bit   m_kill = 1'b0;
   logic [3:0] m_digit = 4'd0;
   logic [3:0] hist[$];

   typedef struct {
      logic [3:0]  d;
      logic [3:0]  e_out;
      logic        e_val;
      logic [15:0] e_cnt;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Expected vote: the latest digit whose run of identical results reached VD
   task automatic ref_eval(output logic [3:0] o, output logic v);
      int run;
      o = 4'd0;
      v = 1'b0;
      run = 0;
      for (int i = 0; i < hist.size(); i++) begin
         run = (i > 0 && hist[i] == hist[i-1]) ? run + 1 : 1;
         if (run >= VD) begin
            o = hist[i];
            v = 1'b1;
         end
      end
   endtask

   task automatic chk_ref(string tag);
      logic [3:0] o;
      logic v;
      ref_eval(o, v);
      chk({tag, "_raw"}, 32'(digit_raw), 32'(hist[$]));
      chk({tag, "_out"}, 32'(digit_out), 32'(o));
      chk({tag, "_val"}, 32'(digit_valid), 32'(v));
      chk({tag, "_cnt"}, 32'(infer_count), 32'(hist.size()));
   endtask

   task automatic chk_reset(string tag);
      chk({tag, "_go"},    32'(lif.lenet_go), 32'd0);
      chk({tag, "_srstn"}, 32'(lif.lenet_srstn), 32'd1);
      chk({tag, "_raw"},   32'(digit_raw), 32'd0);
      chk({tag, "_out"},   32'(digit_out), 32'd0);
      chk({tag, "_val"},   32'(digit_valid), 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_to"},    32'(timeout_err), 32'd0);
      chk({tag, "_ovr"},   32'(overrun), 32'd0);
      chk({tag, "_cnt"},   32'(infer_count), 32'd0);
   endtask

   task automatic pulse_dr();
      rise_cyc = cyc;
      data_ready = 1'b1;
      repeat (4) @(negedge clk);
      data_ready = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_cnt(logic [15:0] tgt, int budget, string name);
      int n = 0;
      while (infer_count !== tgt && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(infer_count), 32'(tgt));
   endtask

   task automatic wait_ready_low(int budget, string name);
      int n = 0;
      while (lif.lenet_ready !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(lif.lenet_ready), 32'd0);
   endtask

   task automatic wait_go(int g0, int budget, string name);
      int n = 0;
      while (go_cnt == g0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(go_cnt - g0), 32'd1);
   endtask

   task automatic run_frame(logic [3:0] d, string name);
      logic [15:0] c0;
      c0 = infer_count;
      m_digit = d;
      pulse_dr();
      wait_cnt(c0 + 16'd1, 2000, name);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (lif.lenet_go === 1'b1) begin
            go_cnt++;
            go_cyc = cyc;
            if (go_prev) go_dbl = 1'b1;
         end
         go_prev = (lif.lenet_go === 1'b1);
         if (infer_count !== cnt_prev) cnt_cyc = cyc;
         cnt_prev = infer_count;
      end
   end

   initial begin
      lif.lenet_ready = 1'b1;
      lif.lenet_digit = 4'd0;
      forever begin
         @(posedge clk);
         #1;
         if (m_kill || lif.lenet_srstn === 1'b0) begin
            m_ph = 0;
            lif.lenet_ready = 1'b1;
         end else begin
            case (m_ph)
               0: if (lif.lenet_go === 1'b1 && !m_hang) begin
                  m_ph = 1;
                  m_t  = m_drop;
               end
               1: if (m_t <= 1) begin
                  lif.lenet_ready = 1'b0;
                  m_ph = 2;
                  m_t  = m_run;
               end else m_t--;
               2: if (m_t <= 1) begin
                  lif.lenet_ready = 1'b1;
                  lif.lenet_digit = m_digit;
                  hist.push_back(m_digit);
                  r_cyc = cyc;
                  m_ph  = 0;
               end else m_t--;
               default: m_ph = 0;
            endcase
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] c0;
      int g0;
      int g1;
      int low;
      int n;

      tbl[0] = '{d: 4'd7, e_out: 4'd0, e_val: 1'b0, e_cnt: 16'd1};
      tbl[1] = '{d: 4'd7, e_out: 4'd0, e_val: 1'b0, e_cnt: 16'd2};
      tbl[2] = '{d: 4'd7, e_out: 4'd7, e_val: 1'b1, e_cnt: 16'd3};
      tbl[3] = '{d: 4'd3, e_out: 4'd7, e_val: 1'b1, e_cnt: 16'd4};
      tbl[4] = '{d: 4'd3, e_out: 4'd7, e_val: 1'b1, e_cnt: 16'd5};
      tbl[5] = '{d: 4'd7, e_out: 4'd7, e_val: 1'b1, e_cnt: 16'd6};

      rst_n = 1'b0;
      enable = 1'b0;
      data_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("rst");
      rst_n = 1'b1;
      @(negedge clk);
      enable = 1'b1;
      repeat (5) @(negedge clk);
      chk("arm_no_go", 32'(go_cnt), 32'd0);
      chk("arm_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 6; i++) begin
         g0 = go_cnt;
         run_frame(tbl[i].d, "tbl_done");
         chk("tbl_go", 32'(go_cnt - g0), 32'd1);
         chk("tbl_go_lat", 32'(go_cyc - rise_cyc), 32'd4);
         chk("tbl_done_lat", 32'(cnt_cyc - r_cyc), 32'd2);
         chk("tbl_raw", 32'(digit_raw), 32'(tbl[i].d));
         chk("tbl_out", 32'(digit_out), 32'(tbl[i].e_out));
         chk("tbl_val", 32'(digit_valid), 32'(tbl[i].e_val));
         chk("tbl_cnt", 32'(infer_count), 32'(tbl[i].e_cnt));
      end

      c0 = infer_count;
      g0 = go_cnt;
      m_digit = 4'd5;
      pulse_dr();
      wait_go(g0, 100, "ovr_go1");
      chk("ovr_pre", 32'(overrun), 32'd0);
      repeat (3) pulse_dr();
      chk("ovr_mid_go", 32'(go_cnt - g0), 32'd1);
      wait_cnt(c0 + 16'd2, 3000, "ovr_done2");
      repeat (300) @(negedge clk);
      chk("ovr_flag", 32'(overrun), 32'd1);
      chk("ovr_go", 32'(go_cnt - g0), 32'd2);
      chk_ref("ovr");

      m_hang = 1'b1;
      c0 = infer_count;
      g0 = go_cnt;
      pulse_dr();
      wait_go(g0, 100, "to_go");
      n = 0;
      while (cyc < go_cyc + T_TO - 1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("to_early_err", 32'(timeout_err), 32'd0);
      chk("to_early_srstn", 32'(lif.lenet_srstn), 32'd1);
      @(negedge clk);
      chk("to_err", 32'(timeout_err), 32'd1);
      low = 0;
      for (int i = 0; i < 30; i++) begin
         if (lif.lenet_srstn === 1'b0) low++;
         @(negedge clk);
      end
      chk("to_srst_len", 32'(low), 32'(SR));
      chk("to_cnt", 32'(infer_count), 32'(c0));
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_sticky", 32'(timeout_err), 32'd1);
      m_hang = 1'b0;

      g0 = go_cnt;
      m_digit = 4'd2;
      pulse_dr();
      chk("rearm_go", 32'(go_cnt - g0), 32'd1);
      wait_cnt(c0 + 16'd1, 2000, "rearm_done");
      repeat (3) @(negedge clk);
      chk_ref("rearm");

      c0 = infer_count;
      g0 = go_cnt;
      m_digit = 4'd9;
      pulse_dr();
      wait_ready_low(100, "en_wait_done");
      repeat (10) @(negedge clk);
      enable = 1'b0;
      wait_cnt(c0 + 16'd1, 1000, "en_done");
      repeat (5) @(negedge clk);
      chk("en_raw", 32'(digit_raw), 32'd9);
      chk("en_busy", 32'(busy), 32'd0);
      pulse_dr();
      pulse_dr();
      repeat (20) @(negedge clk);
      enable = 1'b1;
      repeat (20) @(negedge clk);
      chk("en_no_go", 32'(go_cnt - g0), 32'd1);

      m_digit = 4'd4;
      pulse_dr();
      wait_ready_low(100, "rst_wait_done");
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      m_kill = 1'b1;
      #1;
      chk_reset("mid_rst");
      hist.delete();
      g1 = go_cnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      m_kill = 1'b0;
      repeat (30) @(negedge clk);
      chk("rst_no_go", 32'(go_cnt - g1), 32'd0);
      run_frame(4'd2, "post_rst_done");
      chk("post_rst_go", 32'(go_cnt - g1), 32'd1);
      chk_ref("post_rst");

      for (int i = 0; i < 20; i++) begin
         m_drop = int'($urandom_range(1, 8));
         m_run  = int'($urandom_range(3, 60));
         g0 = go_cnt;
         run_frame(4'($urandom_range(0, 3)), "rnd_done");
         chk("rnd_go", 32'(go_cnt - g0), 32'd1);
         chk_ref("rnd");
      end

      chk("go_width", 32'(go_dbl), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
